// File: rtl/id_stage_rf_if.sv
// Decode-to-EX bus for id_stage_rf: decode slot, writeback port, hazard
// controls and the registered ID/EX outputs. The upstream pipeline drives
// through the master modport; the decode stage sits on the slave modport.
interface id_stage_rf_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  // decode slot
  logic              in_valid;
  logic [31:0]       instruction;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus_4;
  logic [CTRL_W-1:0] ctrl_in;
  logic [XLEN-1:0]   imm_in;
  logic              in_is_load;
  // writeback port
  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  // hazard controls
  logic              stall;
  logic              flush;
  // combinational decode-side outputs
  logic [4:0]        rs1_d;
  logic [4:0]        rs2_d;
  logic              illegal_reg_d;
  logic              load_use_stall;
  // ID/EX register
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_pc_plus_4;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic              ex_is_load;

  modport master (
    output in_valid, instruction, pc, pc_plus_4, ctrl_in, imm_in, in_is_load,
    output wb_en, wb_rd, wb_data, stall, flush,
    input  rs1_d, rs2_d, illegal_reg_d, load_use_stall,
    input  ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
    input  ex_pc_plus_4, ex_rs1, ex_rs2, ex_rd, ex_is_load
  );

  modport slave (
    input  in_valid, instruction, pc, pc_plus_4, ctrl_in, imm_in, in_is_load,
    input  wb_en, wb_rd, wb_data, stall, flush,
    output rs1_d, rs2_d, illegal_reg_d, load_use_stall,
    output ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
    output ex_pc_plus_4, ex_rs1, ex_rs2, ex_rd, ex_is_load
  );
endinterface

// File: rtl/id_stage_rf.sv
// Decode stage datapath: architectural register file with write-through
// bypass, load-use hazard detection and the ID/EX pipeline register.
// ID/EX priority: flush > stall > load-use bubble > capture.
module id_stage_rf #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  id_stage_rf_if.slave bus
);
  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus_4;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              is_load;
  } ex_t;

  // index exists in this configuration (x0 included)
  function automatic logic reg_exists(input logic [4:0] r);
    return ({27'd0, r} < $unsigned(NREGS));
  endfunction

  // index names a writable, readable non-zero register
  function automatic logic reg_live(input logic [4:0] r);
    return (r != 5'd0) && reg_exists(r);
  endfunction

  logic [XLEN-1:0] rf_q [NREGS];
  ex_t             ex_q, ex_d;

  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            wr_en;
  logic            lus;
  logic            unused_opc;

  assign rs1 = bus.instruction[19:15];
  assign rs2 = bus.instruction[24:20];
  assign rd  = bus.instruction[11:7];

  // opcode/funct fields are decoded elsewhere
  assign unused_opc = ^{bus.instruction[31:25], bus.instruction[14:12],
                        bus.instruction[6:0]};

  // out-of-range and x0 writes are silently dropped
  assign wr_en = bus.wb_en && reg_live(bus.wb_rd);

  // register file write; independent of every hazard control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[bus.wb_rd[IDXW-1:0]] <= bus.wb_data;
    end
  end

  // rs1 read with write-through bypass from the same-edge writeback
  always_comb begin
    rs1_val = '0;
    if (reg_live(rs1)) begin
      if (bus.wb_en && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;
      else                                  rs1_val = rf_q[rs1[IDXW-1:0]];
    end
  end

  // rs2 read with write-through bypass from the same-edge writeback
  always_comb begin
    rs2_val = '0;
    if (reg_live(rs2)) begin
      if (bus.wb_en && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
      else                                  rs2_val = rf_q[rs2[IDXW-1:0]];
    end
  end

  // a load in EX whose destination feeds the decode instruction
  assign lus = bus.in_valid && ex_q.valid && ex_q.is_load &&
               (ex_q.rd != 5'd0) && ((ex_q.rd == rs1) || (ex_q.rd == rs2));

  // ID/EX next state; a bubble clears every field including data
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.stall) begin
      ex_d = ex_q;
    end else if (lus || !bus.in_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.ctrl      = bus.ctrl_in;
      ex_d.rs1_data  = rs1_val;
      ex_d.rs2_data  = rs2_val;
      ex_d.imm       = bus.imm_in;
      ex_d.pc        = bus.pc;
      ex_d.pc_plus_4 = bus.pc_plus_4;
      ex_d.rs1       = rs1;
      ex_d.rs2       = rs2;
      ex_d.rd        = rd;
      ex_d.is_load   = bus.in_is_load;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign bus.rs1_d          = rs1;
  assign bus.rs2_d          = rs2;
  assign bus.illegal_reg_d  = bus.in_valid &&
                              (!reg_exists(rs1) || !reg_exists(rs2) || !reg_exists(rd));
  assign bus.load_use_stall = lus;

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.ex_rs1_data  = ex_q.rs1_data;
  assign bus.ex_rs2_data  = ex_q.rs2_data;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_pc_plus_4 = ex_q.pc_plus_4;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_is_load   = ex_q.is_load;
endmodule

// File: tb/tb_id_stage_rf.sv
// Bench for id_stage_rf: two instances (32 and 16 registers) share one
// stimulus stream; a reference model pushes expected ID/EX contents into
// per-instance queues that a separate monitor pops after each posedge.
module tb_id_stage_rf;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus_4;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              is_load;
  } ex_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [31:0]       instruction;
  logic [XLEN-1:0]   pc, pc_plus_4, imm_in, wb_data;
  logic [CTRL_W-1:0] ctrl_in;
  logic              in_is_load, wb_en, stall, flush;
  logic [4:0]        wb_rd;

  id_stage_rf_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) b0 ();
  id_stage_rf_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) b1 ();

  assign b0.in_valid = in_valid;       assign b1.in_valid = in_valid;
  assign b0.instruction = instruction; assign b1.instruction = instruction;
  assign b0.pc = pc;                   assign b1.pc = pc;
  assign b0.pc_plus_4 = pc_plus_4;     assign b1.pc_plus_4 = pc_plus_4;
  assign b0.ctrl_in = ctrl_in;         assign b1.ctrl_in = ctrl_in;
  assign b0.imm_in = imm_in;           assign b1.imm_in = imm_in;
  assign b0.in_is_load = in_is_load;   assign b1.in_is_load = in_is_load;
  assign b0.wb_en = wb_en;             assign b1.wb_en = wb_en;
  assign b0.wb_rd = wb_rd;             assign b1.wb_rd = wb_rd;
  assign b0.wb_data = wb_data;         assign b1.wb_data = wb_data;
  assign b0.stall = stall;             assign b1.stall = stall;
  assign b0.flush = flush;             assign b1.flush = flush;

  id_stage_rf #(.XLEN(XLEN), .NREGS(32), .CTRL_W(CTRL_W)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  id_stage_rf #(.XLEN(XLEN), .NREGS(16), .CTRL_W(CTRL_W)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  ex_t q0[$];
  ex_t q1[$];
  logic [XLEN-1:0] mrf [2][32];
  ex_t mex [2];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int nregs(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic ex_t get_ex(input int k);
    if (k == 0)
      return {b0.ex_valid, b0.ex_ctrl, b0.ex_rs1_data, b0.ex_rs2_data, b0.ex_imm,
              b0.ex_pc, b0.ex_pc_plus_4, b0.ex_rs1, b0.ex_rs2, b0.ex_rd, b0.ex_is_load};
    return {b1.ex_valid, b1.ex_ctrl, b1.ex_rs1_data, b1.ex_rs2_data, b1.ex_imm,
            b1.ex_pc, b1.ex_pc_plus_4, b1.ex_rs1, b1.ex_rs2, b1.ex_rd, b1.ex_is_load};
  endfunction

  // {rs1_d, rs2_d, illegal_reg_d, load_use_stall}
  function automatic logic [11:0] get_comb(input int k);
    if (k == 0) return {b0.rs1_d, b0.rs2_d, b0.illegal_reg_d, b0.load_use_stall};
    return {b1.rs1_d, b1.rs2_d, b1.illegal_reg_d, b1.load_use_stall};
  endfunction

  // architectural read as seen by decode during the current cycle
  function automatic logic [XLEN-1:0] mread(input int k, input logic [4:0] r);
    if (r == 0 || int'(r) >= nregs(k)) return '0;
    if (wb_en && wb_rd == r) return wb_data;
    return mrf[k][r];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, rs1, rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] ldw(input logic [4:0] rd, rs1);
    return {12'h010, rs1, 3'b010, rd, 7'h03};
  endfunction

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)  return 5'(r);
    if (r == 6) return 5'd20;
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic set_dec(input logic v, input logic [31:0] ins, input logic ld);
    in_valid = v; instruction = ins; in_is_load = ld;
    pc = $urandom & 32'hFFFF_FFFC; pc_plus_4 = pc + 32'd4;
    ctrl_in = CTRL_W'($urandom); imm_in = $urandom;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [XLEN-1:0] d);
    wb_en = en; wb_rd = rd; wb_data = d;
  endtask

  task automatic idle();
    set_dec(1'b0, 32'h0, 1'b0);
    set_wb(1'b0, 5'd0, '0);
    stall = 1'b0; flush = 1'b0;
  endtask

  // Called just after a negedge with inputs driven: check decode-side
  // outputs, predict the ID/EX contents after the coming edge, queue them.
  task automatic step();
    logic [4:0] rs1, rs2, rd;
    logic       lus, ill;
    ex_t        nx;
    rs1 = instruction[19:15];
    rs2 = instruction[24:20];
    rd  = instruction[11:7];
    #1;
    for (int k = 0; k < 2; k++) begin
      lus = in_valid && mex[k].valid && mex[k].is_load && mex[k].rd != 0 &&
            (mex[k].rd == rs1 || mex[k].rd == rs2);
      ill = in_valid && (int'(rs1) >= nregs(k) || int'(rs2) >= nregs(k) ||
                         int'(rd) >= nregs(k));
      chk($sformatf("comb%0d", k), get_comb(k), {rs1, rs2, ill, lus});
      if (flush)                   nx = '0;
      else if (stall)              nx = mex[k];
      else if (lus || !in_valid)   nx = '0;
      else nx = '{valid: 1'b1, ctrl: ctrl_in, rs1_data: mread(k, rs1),
                  rs2_data: mread(k, rs2), imm: imm_in, pc: pc,
                  pc_plus_4: pc_plus_4, rs1: rs1, rs2: rs2, rd: rd,
                  is_load: in_is_load};
      if (k == 0) q0.push_back(nx);
      else        q1.push_back(nx);
      mex[k] = nx;
      if (wb_en && wb_rd != 0 && int'(wb_rd) < nregs(k)) mrf[k][wb_rd] = wb_data;
    end
    @(negedge clk);
  endtask

  // asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ex0", get_ex(0), '0);
    chk("rst_ex1", get_ex(1), '0);
    mex[0] = '0; mex[1] = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) mrf[k][i] = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor: compare ID/EX against the scoreboard after each edge
  initial begin
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); chk("ex32", get_ex(0), e); end
      if (q1.size() > 0) begin e = q1.pop_front(); chk("ex16", get_ex(1), e); end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    do_reset();

    // reading x5 right after reset
    set_dec(1'b1, rtype(5'd1, 5'd5, 5'd5), 1'b0); step();

    // same-edge bypass
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    set_dec(1'b1, rtype(5'd1, 5'd5, 5'd0), 1'b0); step();
    idle(); step();

    // x0 writes dropped
    set_wb(1'b1, 5'd0, 32'h1234); set_dec(1'b1, rtype(5'd1, 5'd0, 5'd0), 1'b0); step();
    idle(); set_dec(1'b1, rtype(5'd2, 5'd0, 5'd5), 1'b0); step();

    // x20 out of range for the 16-register instance
    idle(); set_wb(1'b1, 5'd20, 32'd7); step();
    idle(); set_dec(1'b1, rtype(5'd6, 5'd20, 5'd5), 1'b0); step();

    // load-use: lw x3 then add x4,x3,x2 (bubble, then capture)
    idle(); set_wb(1'b1, 5'd2, 32'h22); set_dec(1'b1, ldw(5'd3, 5'd5), 1'b1); step();
    idle(); set_dec(1'b1, rtype(5'd4, 5'd3, 5'd2), 1'b0); step();
    step();
    idle(); step();

    // flush and stall together, then a 3-cycle stall with writeback
    set_dec(1'b1, rtype(5'd7, 5'd5, 5'd2), 1'b0); step();
    set_dec(1'b1, rtype(5'd8, 5'd5, 5'd2), 1'b0); flush = 1'b1; stall = 1'b1; step();
    idle(); set_dec(1'b1, rtype(5'd8, 5'd2, 5'd5), 1'b0); step();
    stall = 1'b1; set_wb(1'b1, 5'd10, 32'hA5A5); set_dec(1'b1, rtype(5'd1, 5'd10, 5'd0), 1'b0); step();
    set_wb(1'b0, 5'd0, '0); step();
    step();
    stall = 1'b0; step();

    // writeback during flush still lands
    idle(); set_wb(1'b1, 5'd9, 32'h55); flush = 1'b1;
    set_dec(1'b1, rtype(5'd1, 5'd9, 5'd9), 1'b0); step();
    idle(); set_dec(1'b1, rtype(5'd1, 5'd9, 5'd10), 1'b0); step();

    // stall on top of load-use keeps the hazard up, reset clears it
    idle(); set_dec(1'b1, ldw(5'd3, 5'd0), 1'b1); step();
    idle(); set_dec(1'b1, rtype(5'd4, 5'd3, 5'd2), 1'b0); stall = 1'b1; step();
    step();
    do_reset();
    stall = 1'b0; step();
    idle(); step();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic ld;
      ld = ($urandom_range(0, 9) < 3);
      set_dec(($urandom_range(0, 99) < 85),
              {7'($urandom), pick_reg(), pick_reg(), 3'($urandom), pick_reg(),
               ld ? 7'h03 : 7'h33}, ld);
      set_wb(($urandom_range(0, 1) == 1), pick_reg(), $urandom);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    idle(); step();
    chk("sb_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_rf.md
# id_stage_rf

Parametrised decode-stage datapath for the pipelined RISC-V core: holds the architectural register file and the ID/EX pipeline register, and resolves load-use hazards locally. Writeback happens on the rising edge with write-through bypass, so no negedge logic is needed. Stall, flush and bubble priority are defined precisely. Sits between the IF/ID register and EX. The existing control unit and immediate generator feed it combinationally through `ctrl_in` and `imm_in`.

## Interface
- `XLEN`, 32: datapath width (32 or 64).
- `NREGS`, 32: architectural registers (16 for RV32E, 32 for RV32I).
- `CTRL_W`, 16: width of the opaque packed control bus from the control unit.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: IF/ID slot holds a real instruction.
- `instruction` in 32: instruction in decode.
- `pc`, `pc_plus_4` in XLEN: PC values of the decode instruction.
- `ctrl_in` in CTRL_W: control bundle for `instruction`.
- `imm_in` in XLEN: immediate for `instruction`.
- `in_is_load` in 1: decode instruction is a load.
- `wb_en` in 1: writeback request.
- `wb_rd` in 5: writeback destination.
- `wb_data` in XLEN: writeback value.
- `stall` in 1: global freeze of ID/EX from the hazard unit.
- `flush` in 1: synchronous kill of the decode slot (taken branch or jump).
- `rs1_d`, `rs2_d` out 5: combinational source indices (`instruction[19:15]`, `instruction[24:20]`).
- `illegal_reg_d` out 1: combinational; `in_valid` and rs1, rs2 or rd is at least `NREGS`.
- `load_use_stall` out 1: combinational; IF/ID must hold this cycle.
- `ex_valid` out 1: ID/EX slot is valid.
- `ex_ctrl` out CTRL_W: registered control bundle.
- `ex_rs1_data`, `ex_rs2_data`, `ex_imm`, `ex_pc`, `ex_pc_plus_4` out XLEN: registered operands and PC values.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5: registered indices.
- `ex_is_load` out 1: registered load flag.

## Operation
- **Register file.** `NREGS` x `XLEN` storage.
  - A write occurs on posedge when `wb_en` is high, `wb_rd` is not 0 and `wb_rd` is below `NREGS`. All other write requests are dropped.
  - Writeback is independent of `stall`, `flush` and `load_use_stall`.
- **Read path.** Combinational, per source index `rs`:
  - If `rs` is 0 or `rs` is at least `NREGS`, the read returns 0.
  - Else, if `wb_en` is high and `wb_rd` equals `rs`, the read returns `wb_data` (write-through bypass).
  - Else the read returns the stored value.
- **Load-use hazard.** `load_use_stall` is high when all of the following hold:
  - `in_valid`, `ex_valid` and `ex_is_load` are high;
  - `ex_rd` is not 0;
  - `ex_rd` equals `rs1_d` or `rs2_d`.
- **ID/EX update priority** (highest first):
  1. `flush`: load a bubble.
  2. `stall`: hold all `ex_*` outputs.
  3. `load_use_stall`: load a bubble.
  4. Otherwise: capture the decode slot.
- **Bubble.** `ex_valid`, `ex_ctrl`, `ex_rd`, `ex_rs1`, `ex_rs2` and `ex_is_load` become 0. Data fields (`ex_rs1_data`, `ex_rs2_data`, `ex_imm`, `ex_pc`, `ex_pc_plus_4`) are don't-care; they are also cleared to 0.
- **Capture.** Each `ex_*` output takes its decode-side value:
  - `ex_valid` takes `in_valid`; `ex_ctrl` takes `ctrl_in`; `ex_imm` takes `imm_in`; `ex_is_load` takes `in_is_load`.
  - `ex_rs1_data` and `ex_rs2_data` take the bypassed read values.
  - `ex_rd` takes `instruction[11:7]`; `ex_rs1` takes `rs1_d`; `ex_rs2` takes `rs2_d`.
  - `ex_pc` takes `pc`; `ex_pc_plus_4` takes `pc_plus_4`.
- **Invalid slot.** When `in_valid` is low, capture loads a bubble.
- **Illegal register.** The `illegal_reg_d` flag is informational only; the instruction still proceeds.

## Timing
- **Reset.** Asserting `reset` asynchronously clears every register-file entry and every `ex_*` output to 0. Outputs stay 0 until the first posedge after release.
- **Latency.** One cycle from the decode slot to `ex_*`.
- **Same-cycle bypass.** A value written at edge N is visible in the `ex_*_data` captured at edge N. No RAW gap exists between WB and ID.
- **Flush vs. stall.** `flush` is sampled only at posedge; it is not in the sensitivity list. When `flush` and `stall` are both high, `flush` wins.
- **Stall duration.** `load_use_stall` lasts exactly one cycle per hazard, because the inserted bubble clears `ex_is_load`.
- **Stall vs. load-use.** With `stall` and `load_use_stall` both high, ID/EX holds. The load is still in EX afterward, so `load_use_stall` stays asserted until `stall` drops.
- **Reset mid-stall.** Asserting `reset` during a stall immediately clears all state. No hazard is reported after release.

## Test plan
- **Reset.** Assert reset with `ex_*` non-zero -> all `ex_*` are 0 immediately. After release, reading x5 gives 0.
- **Bypass.** Same edge: `wb_en`=1, `wb_rd`=5, `wb_data`=0xDEADBEEF; decode `add x1,x5,x0` -> next cycle `ex_rs1_data`=0xDEADBEEF, `ex_rs2_data`=0.
- **x0 and RV32E.** Write x0=0x1234 -> reads of x0 return 0. With `NREGS`=16, write x20=7, then read x20 -> returns 0 and `illegal_reg_d`=1.
- **Load-use.** `lw x3` in EX, decode `add x4,x3,x2` -> `load_use_stall`=1 for one cycle, then `ex_valid`=0 and `ex_ctrl`=0. The next cycle the add is captured with `load_use_stall`=0.
- **Flush vs. stall.** `flush`=1 and `stall`=1 at the same edge -> `ex_valid`=0. With `stall` alone, `ex_*` hold their values for 3 cycles, and a writeback during the stall still lands in the register file.
- **Writeback during flush.** `wb_en`=1, `wb_rd`=9, `wb_data`=0x55 with `flush`=1 -> x9 reads 0x55 afterward.
